// File: rtl/noc_pkt_arbiter_if.sv
// Bundle of request/grant signals between packet sources and noc_pkt_arbiter.
//   master : drives req, last, out_ready; observes the grant side.
//   slave  : the arbiter; consumes req/last/out_ready and drives gnt, gnt_id, out_valid, locked.
// Signals:
//   req       [N]    per-input request, held while a beat is pending
//   last      [N]    per-input tail-beat flag, qualified by req of the same index
//   out_ready        downstream accepts the granted beat this cycle
//   gnt       [N]    one-hot grant, zero when nothing is granted
//   gnt_id    [IDW]  binary index of the granted input, zero when gnt is zero
//   out_valid        |gnt
//   locked           a packet is in flight and its owner is held
interface noc_pkt_arbiter_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]   req;
  logic [N-1:0]   last;
  logic           out_ready;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           out_valid;
  logic           locked;

  modport master (
    output req,
    output last,
    output out_ready,
    input  gnt,
    input  gnt_id,
    input  out_valid,
    input  locked
  );

  modport slave (
    input  req,
    input  last,
    input  out_ready,
    output gnt,
    output gnt_id,
    output out_valid,
    output locked
  );
endinterface

// File: rtl/noc_pkt_arbiter.sv
// N-to-1 packet-aware arbiter for the NoC/AXI2AHB data path.
// Picks one requesting input per packet (fixed priority or round robin) and holds that grant
// from the first accepted beat until the accepted beat flagged last (wormhole lock).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    noc_pkt_arbiter_if.slave: req/last/out_ready in, gnt/gnt_id/out_valid/locked out
package noc_global;
  typedef enum logic [1:0] {
    ARB_TYPES_NONE = 2'd0,
    ARB_TYPES_FPA  = 2'd1,
    ARB_TYPES_RR   = 2'd2
  } ArbForm;
endpackage

module noc_pkt_arbiter
  import noc_global::*;
#(
  parameter int unsigned N        = 4,
  parameter ArbForm      ARB_TYPE = ARB_TYPES_RR,
  parameter int unsigned IDW      = (N > 1) ? $clog2(N) : 1
) (
  input logic              clk,
  input logic              rst_n,
  noc_pkt_arbiter_if.slave bus
);

  // Pass-through makes sense only for a single input.
  if (ARB_TYPE == ARB_TYPES_NONE && N > 1) begin : g_bad_cfg
    $error("noc_pkt_arbiter: ARB_TYPE NONE requires N == 1");
  end

  // One extra bit so rr_ptr + k can be wrapped without overflow.
  localparam int unsigned SW = IDW + 1;

  logic           lock_q, lock_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic [N-1:0]   req, last;
  logic           out_ready;
  logic [N-1:0]   free_gnt;
  logic [N-1:0]   own_mask;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           out_valid;
  logic           accept;
  logic           tail;

  assign req       = bus.req;
  assign last      = bus.last;
  assign out_ready = bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q   <= 1'b0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Winner among all inputs when no packet is in flight. The scan order starts at rr_ptr for
  // round robin and at 0 for fixed priority; the first requester in that order wins.
  always_comb begin
    logic           found;
    logic [SW-1:0]  sum;
    logic [IDW-1:0] idx;
    free_gnt = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    if (ARB_TYPE == ARB_TYPES_NONE) begin
      free_gnt = req;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        sum = {1'b0, rr_ptr_q} + SW'(k);
        if (sum >= SW'(N)) sum = sum - SW'(N);
        idx = (ARB_TYPE == ARB_TYPES_RR) ? sum[IDW-1:0] : IDW'(k);
        if (!found && req[idx]) begin
          free_gnt[idx] = 1'b1;
          found         = 1'b1;
        end
      end
    end
  end

  always_comb begin
    own_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      own_mask[i] = (owner_q == IDW'(i));
    end
  end

  // Output logic: while locked only the owner can be granted, and only while it requests.
  always_comb begin
    gnt    = lock_q ? (req & own_mask) : free_gnt;
    gnt_id = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) gnt_id = gnt_id | IDW'(i);
    end
    out_valid = |gnt;
    accept    = out_valid & out_ready;
    tail      = |(gnt & last);
  end

  // Next-state logic: lock on a non-tail accepted beat, release (and advance the RR pointer)
  // on an accepted tail. Stalled cycles leave everything untouched.
  always_comb begin
    lock_d   = lock_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (tail) begin
        lock_d = 1'b0;
        if (ARB_TYPE == ARB_TYPES_RR) begin
          rr_ptr_d = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
        end
      end else begin
        lock_d  = 1'b1;
        owner_d = gnt_id;
      end
    end
  end

  assign bus.gnt       = gnt;
  assign bus.gnt_id    = gnt_id;
  assign bus.out_valid = out_valid;
  assign bus.locked    = lock_q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_gnt_has_req: assert property (@(posedge clk) disable iff (!rst_n) (gnt & ~req) == '0);
  a_lock_owner: assert property (@(posedge clk) disable iff (!rst_n)
                                 !lock_q || ((gnt & ~own_mask) == '0));

endmodule

// File: tb/tb_noc_pkt_arbiter.sv
// Bench for noc_pkt_arbiter: one round-robin and one fixed-priority instance share the same
// stimulus; both are compared every cycle against a packet-level reference model, with extra
// directed expectations for the scenarios of interest and a randomized tail.
module tb_noc_pkt_arbiter;
  import noc_global::*;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_s  = '0;
  logic [N-1:0] last_s = '0;
  logic         rdy_s  = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model: per instance (0 = RR, 1 = FPA), the packet owner (-1 = none) and the index
  // that round robin tries first.
  int m_own [2];
  int m_ptr [2];

  // DUT outputs captured at the most recent check point.
  logic [N-1:0]   obs_rr_gnt, obs_fp_gnt;
  logic [IDW-1:0] obs_rr_id, obs_fp_id;
  logic           obs_rr_lock, obs_fp_lock, obs_rr_valid;

  always #5 clk = ~clk;

  noc_pkt_arbiter_if #(.N(N)) bus_rr ();
  noc_pkt_arbiter_if #(.N(N)) bus_fp ();

  assign bus_rr.req       = req_s;
  assign bus_rr.last      = last_s;
  assign bus_rr.out_ready = rdy_s;
  assign bus_fp.req       = req_s;
  assign bus_fp.last      = last_s;
  assign bus_fp.out_ready = rdy_s;

  noc_pkt_arbiter #(.N(N), .ARB_TYPE(ARB_TYPES_RR)) u_rr (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_rr)
  );

  noc_pkt_arbiter #(.N(N), .ARB_TYPE(ARB_TYPES_FPA)) u_fp (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_fp)
  );

  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    return |(v & (N'(1) << i));
  endfunction

  // Index the model expects to be granted for instance p, or -1.
  function automatic int exp_idx(input int p);
    if (m_own[p] >= 0) return bit_at(req_s, m_own[p]) ? m_own[p] : -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p == 0) ? (m_ptr[p] + k) % N : k;
      if (bit_at(req_s, j)) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] idx_vec(input int e);
    return (e < 0) ? '0 : N'(1) << e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_own[p] = -1;
      m_ptr[p] = 0;
    end
  endtask

  // Entered on a falling edge: drive, settle, compare, then advance the model at the rising edge.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic rd);
    int e0, e1;
    req_s  = r;
    last_s = l;
    rdy_s  = rd;
    #2;
    e0 = exp_idx(0);
    e1 = exp_idx(1);
    obs_rr_gnt   = bus_rr.gnt;
    obs_fp_gnt   = bus_fp.gnt;
    obs_rr_id    = bus_rr.gnt_id;
    obs_fp_id    = bus_fp.gnt_id;
    obs_rr_lock  = bus_rr.locked;
    obs_fp_lock  = bus_fp.locked;
    obs_rr_valid = bus_rr.out_valid;
    chk("rr_gnt",    32'(obs_rr_gnt), 32'(idx_vec(e0)));
    chk("rr_gnt_id", 32'(obs_rr_id), (e0 < 0) ? 0 : e0);
    chk("rr_valid",  32'(obs_rr_valid), (e0 >= 0) ? 1 : 0);
    chk("rr_locked", 32'(obs_rr_lock), (m_own[0] >= 0) ? 1 : 0);
    chk("fp_gnt",    32'(obs_fp_gnt), 32'(idx_vec(e1)));
    chk("fp_gnt_id", 32'(obs_fp_id), (e1 < 0) ? 0 : e1);
    chk("fp_valid",  32'(bus_fp.out_valid), (e1 >= 0) ? 1 : 0);
    chk("fp_locked", 32'(obs_fp_lock), (m_own[1] >= 0) ? 1 : 0);
    @(posedge clk);
    if (rd) begin
      if (e0 >= 0) begin
        if (bit_at(l, e0)) begin
          m_own[0] = -1;
          m_ptr[0] = (e0 + 1) % N;
        end else begin
          m_own[0] = e0;
        end
      end
      if (e1 >= 0) m_own[1] = bit_at(l, e1) ? -1 : e1;
    end
    @(negedge clk);
  endtask

  // Entered on a falling edge: pulse reset in mid-cycle, lock must drop at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rr_locked", 32'(bus_rr.locked), 0);
    chk("rst_fp_locked", 32'(bus_fp.locked), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    chk("reset_rr_gnt",    32'(bus_rr.gnt), 0);
    chk("reset_rr_locked", 32'(bus_rr.locked), 0);
    chk("reset_fp_gnt",    32'(bus_fp.gnt), 0);
    chk("reset_fp_locked", 32'(bus_fp.locked), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All inputs request single-beat packets: RR walks 0,1,2,3 and wraps.
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 4'b1111, 1'b1);
      chk("t1_rr_seq", 32'(obs_rr_id), i % 4);
    end

    // Move the pointer to 2, then a 3-beat packet on input 2 with everyone requesting.
    cycle(4'b1111, 4'b1111, 1'b1);
    chk("t2_rr_pre", 32'(obs_rr_id), 1);
    cycle(4'b1111, 4'b0000, 1'b1);
    chk("t2_beat1_gnt", 32'(obs_rr_gnt), 32'h4);
    chk("t2_beat1_lock", 32'(obs_rr_lock), 0);
    cycle(4'b1111, 4'b0000, 1'b1);
    chk("t2_beat2_gnt", 32'(obs_rr_gnt), 32'h4);
    chk("t2_beat2_lock", 32'(obs_rr_lock), 1);
    cycle(4'b1111, 4'b0100, 1'b1);
    chk("t2_beat3_gnt", 32'(obs_rr_gnt), 32'h4);
    chk("t2_beat3_lock", 32'(obs_rr_lock), 1);
    cycle(4'b1111, 4'b1111, 1'b1);
    chk("t2_next_id", 32'(obs_rr_id), 3);

    // Lock to input 1, then its request drops while input 0 waits.
    cycle(4'b0010, 4'b0000, 1'b1);
    chk("t3_first_id", 32'(obs_rr_id), 1);
    for (int i = 0; i < 2; i++) begin
      cycle(4'b0001, 4'b0000, 1'b1);
      chk("t3_gap_gnt", 32'(obs_rr_gnt), 0);
      chk("t3_gap_valid", 32'(obs_rr_valid), 0);
    end
    cycle(4'b0011, 4'b0010, 1'b1);
    chk("t3_tail_id", 32'(obs_rr_id), 1);
    cycle(4'b0001, 4'b1111, 1'b1);
    chk("t3_after_gnt", 32'(obs_rr_gnt), 32'h1);

    // Fixed priority starves input 3 while input 1 requests.
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1010, 4'b1111, 1'b1);
      chk("t4_fp_id", 32'(obs_fp_id), 1);
    end

    // Stall: grant holds, nothing locks, pointer does not move.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0110, 4'b1111, 1'b0);
      chk("t5_stall_gnt", 32'(obs_rr_gnt), 32'h2);
      chk("t5_stall_lock", 32'(obs_rr_lock), 0);
    end
    cycle(4'b0110, 4'b1111, 1'b1);
    chk("t5_ptr_kept", 32'(obs_rr_id), 1);

    // Reset in the middle of a packet owned by input 3.
    do_reset();
    cycle(4'b1000, 4'b0000, 1'b1);
    cycle(4'b1000, 4'b0000, 1'b0);
    chk("t6_rr_locked", 32'(obs_rr_lock), 1);
    chk("t6_fp_locked", 32'(obs_fp_lock), 1);
    do_reset();
    cycle(4'b1001, 4'b0000, 1'b1);
    chk("t6_rr_restart", 32'(obs_rr_id), 0);
    chk("t6_fp_restart", 32'(obs_fp_id), 0);

    // Randomized traffic; tails are somewhat rare so multi-beat packets form.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r, l;
      logic         rd;
      r  = N'($urandom_range(0, 15));
      l  = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      rd = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle(r, l, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
